// File: rtl/dsc_mul_nway.sv
// Deterministic stochastic-computing multiplier: N counter/comparator streams are ANDed and counted,
// giving the exact integer product of the latched operands, with start/busy/done and a stall enable.
module dsc_mul_nway #(
  parameter int SNG_WIDTH  = 10,
  parameter int NUM_INPUTS = 3,
  parameter int EARLY_STOP = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  x,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0]  z,
  output logic                             sn_out
);
  localparam int W  = SNG_WIDTH;
  localparam int N  = NUM_INPUTS;
  localparam int ZW = N * W;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state;
  logic [N-1:0][W-1:0]  cnt;
  logic [N-1:0][W-1:0]  xr;
  logic [N-1:0]         s;
  logic [N:0]           carry;
  logic                 full_end;
  logic                 early_end;

  // carry[i] = all lower counters at their maximum, i.e. counter i steps this cycle
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sng
      assign s[gi]       = (cnt[gi] < xr[gi]);
      assign carry[gi+1] = carry[gi] & (&cnt[gi]);
    end
  endgenerate

  assign full_end  = carry[N];
  // Slowest stream is 0 for the rest of the period once its counter reaches the operand
  assign early_end = (EARLY_STOP != 0) && (cnt[N-1] == xr[N-1]) && (xr[N-1] != '1);

  assign busy   = (state == RUN);
  assign sn_out = (state == RUN) && (&s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      xr    <= '0;
      z     <= '0;
      done  <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            xr    <= x;
            cnt   <= '0;
            z     <= '0;
          end
        end
        RUN: begin
          z <= z + ZW'(sn_out);
          for (int i = 0; i < N; i++) begin
            if (carry[i]) cnt[i] <= cnt[i] + 1'b1;
          end
          if (full_end || early_end) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsc_mul_nway.sv
// Bench for dsc_mul_nway (W=4, N=3): one instance with early stop, one without, sharing stimulus;
// results and run lengths come from plain arithmetic on the operands.
module tb_dsc_mul_nway;
  localparam int W = 4;
  localparam int N = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic          start;
  logic [N*W-1:0] x;
  logic          busy_es, done_es, sn_es;
  logic          busy_full, done_full, sn_full;
  logic [N*W-1:0] z_es, z_full;

  int total = 0;
  int bad   = 0;

  dsc_mul_nway #(.SNG_WIDTH(W), .NUM_INPUTS(N), .EARLY_STOP(1)) dut_es (
    .clk(clk), .rst(rst), .en(en), .start(start), .x(x),
    .busy(busy_es), .done(done_es), .z(z_es), .sn_out(sn_es)
  );

  dsc_mul_nway #(.SNG_WIDTH(W), .NUM_INPUTS(N), .EARLY_STOP(0)) dut_full (
    .clk(clk), .rst(rst), .en(en), .start(start), .x(x),
    .busy(busy_full), .done(done_full), .z(z_full), .sn_out(sn_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a, b, c;
    int         z;
    int         cyc_es;
    int         cyc_full;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Early-stop run length: stream 2 stays low from cycle c*256 onward
  function automatic int model_es_cycles(input int c);
    return (c < 15) ? (c * 256 + 1) : 4096;
  endfunction

  // Start one run on both instances and measure busy length, final z and done width.
  // disturb: pulse start + change x at cycle 100, stall en for 10 cycles from cycle 200.
  task automatic run_one(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input int ez, input int ces, input int cfull,
                         input bit disturb);
    int n_es = 0, n_full = 0, t = 0, sn_bad = 0;
    bit d_es = 0, d_full = 0, exp_sn;
    longint zs_es = 0, zs_full = 0;
    @(negedge clk);
    x = {c, b, a}; start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(d_es && d_full) && t < 6000) begin
      if (busy_es) begin
        if (!disturb) begin
          exp_sn = ((n_es % 16) < a) && (((n_es / 16) % 16) < b) && ((n_es / 256) < c);
          if (sn_es != exp_sn) sn_bad++;
        end
        n_es++;
      end
      if (busy_full) n_full++;
      if (done_es && !d_es) begin d_es = 1; zs_es = z_es; end
      if (done_full && !d_full) begin d_full = 1; zs_full = z_full; end
      if (disturb) begin
        if (t == 100) begin start = 1'b1; x = 12'($urandom); end
        else if (t == 101) start = 1'b0;
        if (t == 200) en = 1'b0;
        else if (t == 210) en = 1'b1;
      end
      t++;
      @(negedge clk);
    end
    if (!(d_es && d_full)) begin
      total++; bad++;
      $display("FAIL %s timeout: got es_done=%0d full_done=%0d expected 1 1", name, d_es, d_full);
    end
    check({name, " z_es"}, zs_es, ez);
    check({name, " z_full"}, zs_full, ez);
    check({name, " cyc_es"}, n_es, ces);
    check({name, " cyc_full"}, n_full, cfull);
    if (!disturb) check({name, " sn_es_bits_wrong"}, sn_bad, 0);
    check({name, " done_pulse_over"}, {done_es, done_full}, 0);
    check({name, " z_held"}, {z_es, z_full}, {12'(ez), 12'(ez)});
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    logic [3:0] ra, rb, rc;
    vecs[0] = '{"all15",   4'd15, 4'd15, 4'd15, 3375, 4096, 4096};
    vecs[1] = '{"3x5x7",   4'd3,  4'd5,  4'd7,  105,  1793, 4096};
    vecs[2] = '{"x2zero",  4'd9,  4'd9,  4'd0,  0,    1,    4096};
    vecs[3] = '{"x0zero",  4'd0,  4'd7,  4'd2,  0,    513,  4096};
    vecs[4] = '{"15x1x14", 4'd15, 4'd1,  4'd14, 210,  3585, 4096};

    rst = 1'b0; en = 1'b0; start = 1'b0; x = '0;
    #2;
    check("reset outs", {busy_es, done_es, sn_es, busy_full, done_full, sn_full}, 0);
    check("reset z", {z_es, z_full}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle sn_out", {sn_es, sn_full}, 0);

    foreach (vecs[i])
      run_one(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].z,
              vecs[i].cyc_es, vecs[i].cyc_full, 1'b0);

    run_one("disturb", 4'd3, 4'd5, 4'd7, 105, 1793 + 10, 4096 + 10, 1'b1);

    // Reset mid-run, then a fresh run
    @(negedge clk);
    x = {4'd7, 4'd5, 4'd3}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun reset outs", {busy_es, done_es, sn_es, busy_full, done_full, sn_full}, 0);
    check("midrun reset z", {z_es, z_full}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_one("after_reset", 4'd2, 4'd2, 4'd2, 8, 513, 4096, 1'b0);

    // Back-to-back on the early-stop instance with start held through done
    @(negedge clk);
    x = {4'd7, 4'd5, 4'd3}; start = 1'b1;
    @(negedge clk);
    x = {4'd4, 4'd3, 4'd2};
    n = 0;
    while (!done_es && n < 6000) begin
      if (busy_es) n++;
      @(negedge clk);
    end
    check("b2b run1 cyc", n, 1793);
    check("b2b run1 z", z_es, 105);
    @(negedge clk);
    start = 1'b0;
    check("b2b restart busy", busy_es, 1);
    n = 0;
    while (!done_es && n < 6000) begin
      if (busy_es) n++;
      @(negedge clk);
    end
    check("b2b run2 cyc", n, 1025);
    check("b2b run2 z", z_es, 24);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int r = 0; r < 5; r++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      run_one($sformatf("rand%0d_%0dx%0dx%0d", r, ra, rb, rc), ra, rb, rc,
              int'(ra) * int'(rb) * int'(rc), model_es_cycles(int'(rc)), 4096, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
